// File: rtl/spdif_pkg.sv
// spdif_pkg: shared SPDIF feeder constants, stereo pair type and feeder state enum
package spdif_pkg;
    localparam int SPDIF_SAMPLE_W = 24;
    typedef struct packed {
        logic [SPDIF_SAMPLE_W-1:0] right;
        logic [SPDIF_SAMPLE_W-1:0] left;
    } spdif_pair_t;
    typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_RUN} feed_state_t;
endpackage

// File: rtl/spdif_sample_feeder_if.sv
// spdif_sample_feeder_if: producer pair stream plus transmitter sample bus and bit enable
interface spdif_sample_feeder_if;
    import spdif_pkg::*;
    logic in_valid;
    logic in_ready;
    logic [SPDIF_SAMPLE_W-1:0] in_left;
    logic [SPDIF_SAMPLE_W-1:0] in_right;
    logic [2*SPDIF_SAMPLE_W-1:0] sample;
    logic sample_req;
    logic bit_out_en;
    modport master (output in_valid, in_left, in_right, sample_req, input in_ready, sample, bit_out_en);
    modport slave (input in_valid, in_left, in_right, sample_req, output in_ready, sample, bit_out_en);
endinterface

// File: rtl/spdif_feed_fifo.sv
// spdif_feed_fifo: synchronous show-ahead stereo-pair FIFO with flush and occupancy
module spdif_feed_fifo
    import spdif_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  spdif_pair_t              wdata_i,
    output spdif_pair_t              rdata_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int AW = $clog2(DEPTH);
    spdif_pair_t mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic do_push;
    logic do_pop;
    assign full_o = level_o == (AW+1)'(DEPTH);
    assign empty_o = level_o == '0;
    assign do_push = push_i && !full_o;
    assign do_pop = pop_i && !empty_o;
    assign rdata_o = mem[rd_ptr];
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level_o <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            level_o <= level_o + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= wdata_i;
    end
endmodule

// File: rtl/spdif_sample_feeder.sv
// spdif_sample_feeder: FIFO-fed SPDIF sample bus with fractional bit enable; SPDIF_FEED_HOLD_EN repeats the last pair on underrun
module spdif_sample_feeder
    import spdif_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int PHASE_W = 32
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          enable_i,
    input  logic [PHASE_W-1:0]            phase_inc_i,
    spdif_sample_feeder_if.slave          feed,
    output logic [$clog2(FIFO_DEPTH):0]   level_o,
    output logic                          running_o,
    output logic                          underrun_o
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    feed_state_t state;
    feed_state_t state_nxt;
    logic [PHASE_W-1:0] acc;
    logic [PHASE_W-1:0] acc_sum;
    logic carry;
    spdif_pair_t head;
    spdif_pair_t in_pair;
    spdif_pair_t fallback;
    logic full;
    logic empty;
    logic push;
    logic pop;
    logic run;
    logic active;
    assign run = state == ST_RUN;
    assign active = enable_i && state != ST_IDLE;
    assign in_pair = '{right: feed.in_right, left: feed.in_left};
    assign feed.in_ready = state != ST_IDLE && !full;
    assign push = enable_i && feed.in_valid && feed.in_ready;
    assign pop = enable_i && run && feed.sample_req && !empty;
    assign {carry, acc_sum} = {1'b0, acc} + {1'b0, phase_inc_i};
    assign running_o = run;
    assign feed.sample = run ? (empty ? fallback : head) : '0;
    spdif_feed_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (!enable_i || state == ST_IDLE),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (in_pair),
        .rdata_o (head),
        .level_o (level_o),
        .full_o  (full),
        .empty_o (empty)
    );
    always_comb begin
        state_nxt = state;
        state_nxt = !enable_i ? ST_IDLE
                  : state == ST_IDLE ? ST_FILL
                  : (state == ST_FILL && level_o >= LW'(FIFO_DEPTH / 2)) ? ST_RUN
                  : state;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
            acc <= '0;
            feed.bit_out_en <= 1'b0;
            underrun_o <= 1'b0;
        end else begin
            state <= state_nxt;
            acc <= active ? acc_sum : '0;
            feed.bit_out_en <= active && carry;
            underrun_o <= enable_i && run && feed.sample_req && empty;
        end
    end
`ifdef SPDIF_FEED_HOLD_EN
    spdif_pair_t hold;
    always_ff @(posedge clk_i) begin
        if (rst_i || !enable_i) hold <= '0;
        else if (pop) hold <= head;
    end
    assign fallback = hold;
`else
    assign fallback = '0;
`endif
endmodule

// File: tb/tb_spdif_sample_feeder.sv
// tb_spdif_sample_feeder: directed checks of reset, bit enable cadence, fill/run, pops, underrun, full and disable
module tb_spdif_sample_feeder;
    logic clk = 1'b0;
    logic rst;
    logic enable;
    logic [31:0] phase_inc;
    logic [3:0] level;
    logic running;
    logic underrun;
    int n_cmp = 0;
    int n_bad = 0;
    logic [47:0] pop_exp [3];
    logic [47:0] fb_exp;

    spdif_sample_feeder_if ff ();

    spdif_sample_feeder #(.FIFO_DEPTH(8), .PHASE_W(32)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .enable_i    (enable),
        .phase_inc_i (phase_inc),
        .feed        (ff),
        .level_o     (level),
        .running_o   (running),
        .underrun_o  (underrun)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        pop_exp[0] = 48'h800001_000002;
        pop_exp[1] = 48'h800002_000003;
        pop_exp[2] = 48'h800003_000004;
`ifdef SPDIF_FEED_HOLD_EN
        fb_exp = 48'h800003_000004;
`else
        fb_exp = 48'h0;
`endif
        rst = 1'b1;
        enable = 1'b1;
        phase_inc = 32'h4000_0000;
        ff.in_valid = 1'b0;
        ff.in_left = '0;
        ff.in_right = '0;
        ff.sample_req = 1'b0;
        repeat (3) step();
        chk("rst_ready", {63'd0, ff.in_ready}, 64'd0);
        chk("rst_bit_en", {63'd0, ff.bit_out_en}, 64'd0);
        chk("rst_sample", {16'd0, ff.sample}, 64'd0);
        chk("rst_level", {60'd0, level}, 64'd0);
        chk("rst_running", {63'd0, running}, 64'd0);
        chk("rst_underrun", {63'd0, underrun}, 64'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", {63'd0, ff.in_ready}, 64'd0);
        chk("post_rst_sample", {16'd0, ff.sample}, 64'd0);
        // Edge k=1 enters FILL, first add at k=2, first carry lands at k=5.
        for (int k = 1; k <= 12; k++) begin
            step();
            chk($sformatf("bit_en_k%0d", k), {63'd0, ff.bit_out_en}, {63'd0, k >= 5 && (k % 4) == 1});
        end
        chk("fill_sample", {16'd0, ff.sample}, 64'd0);
        chk("fill_running", {63'd0, running}, 64'd0);
        chk("fill_ready", {63'd0, ff.in_ready}, 64'd1);
        ff.in_valid = 1'b1;
        for (int n = 0; n < 4; n++) begin
            ff.in_left = 24'h000001 + 24'(n);
            ff.in_right = 24'h800000 + 24'(n);
            step();
        end
        ff.in_valid = 1'b0;
        chk("fill4_level", {60'd0, level}, 64'd4);
        chk("fill4_running", {63'd0, running}, 64'd0);
        step();
        chk("run_running", {63'd0, running}, 64'd1);
        chk("run_head", {16'd0, ff.sample}, {16'd0, 48'h800000_000001});
        for (int i = 0; i < 3; i++) begin
            ff.sample_req = 1'b1;
            step();
            ff.sample_req = 1'b0;
            chk($sformatf("pop%0d_sample", i + 1), {16'd0, ff.sample}, {16'd0, pop_exp[i]});
            chk($sformatf("pop%0d_level", i + 1), {60'd0, level}, 64'(3 - i));
            chk($sformatf("pop%0d_underrun", i + 1), {63'd0, underrun}, 64'd0);
            repeat (63) step();
        end
        ff.sample_req = 1'b1;
        step();
        ff.sample_req = 1'b0;
        chk("drain_level", {60'd0, level}, 64'd0);
        chk("drain_sample", {16'd0, ff.sample}, {16'd0, fb_exp});
        chk("drain_underrun", {63'd0, underrun}, 64'd0);
        ff.sample_req = 1'b1;
        step();
        ff.sample_req = 1'b0;
        chk("ur_pulse", {63'd0, underrun}, 64'd1);
        chk("ur_level", {60'd0, level}, 64'd0);
        chk("ur_sample", {16'd0, ff.sample}, {16'd0, fb_exp});
        chk("ur_running", {63'd0, running}, 64'd1);
        step();
        chk("ur_end", {63'd0, underrun}, 64'd0);
        ff.in_valid = 1'b1;
        for (int n = 0; n < 8; n++) begin
            ff.in_left = 24'h000100 + 24'(n);
            ff.in_right = 24'h000200 + 24'(n);
            step();
        end
        chk("full_level", {60'd0, level}, 64'd8);
        chk("full_ready", {63'd0, ff.in_ready}, 64'd0);
        chk("full_head", {16'd0, ff.sample}, {16'd0, 48'h000200_000100});
        ff.in_left = 24'h0000AA;
        ff.in_right = 24'h0000BB;
        ff.sample_req = 1'b1;
        step();
        ff.sample_req = 1'b0;
        ff.in_valid = 1'b0;
        chk("fullpop_level", {60'd0, level}, 64'd7);
        chk("fullpop_head", {16'd0, ff.sample}, {16'd0, 48'h000201_000101});
        chk("fullpop_ready", {63'd0, ff.in_ready}, 64'd1);
        ff.in_valid = 1'b1;
        enable = 1'b0;
        step();
        ff.in_valid = 1'b0;
        chk("dis_level", {60'd0, level}, 64'd0);
        chk("dis_running", {63'd0, running}, 64'd0);
        chk("dis_bit_en", {63'd0, ff.bit_out_en}, 64'd0);
        chk("dis_ready", {63'd0, ff.in_ready}, 64'd0);
        chk("dis_sample", {16'd0, ff.sample}, 64'd0);
        repeat (4) step();
        chk("idle_bit_en", {63'd0, ff.bit_out_en}, 64'd0);
        chk("idle_level", {60'd0, level}, 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
